// File: rtl/udm_uart_pkg.sv
// ---------------------------------------------------------------------------
// udm_uart_pkg
// Shared definitions for the UDM debug-link UART (transmitter and receiver).
//   - uart_state_e : frame-level state of a UART serialiser / deserialiser
//   - UART_DATA_W  : data bits per frame (fixed at 8)
//   - DIV_*        : clocks-per-bit divider values for a 100 MHz system clock
//   - parity_bit() : parity bit value for a data byte
// ---------------------------------------------------------------------------
package udm_uart_pkg;

    localparam int UART_DATA_W = 8;

    // Bit-period divider values at 100 MHz.
    localparam int DIV_115200 = 868;
    localparam int DIV_19200  = 5208;
    localparam int DIV_9600   = 10416;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data,
                                        input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/udm_uart_bitcnt.sv
// ---------------------------------------------------------------------------
// udm_uart_bitcnt
// Loadable down-counter that marks the last clock of a UART bit.
// The owner loads (period - 1) at every bit boundary; bit_end_o is high on
// the cycle the count reaches zero, i.e. the final cycle of the current bit.
//   clk_i       : system clock
//   arst_i      : asynchronous active-high reset
//   load_i      : reload the counter this cycle
//   load_val_i  : value to load (clocks in the bit minus one)
//   bit_end_o   : counter is at zero (last cycle of the bit)
// ---------------------------------------------------------------------------
module udm_uart_bitcnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             bit_end_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/udm_uart_tx.sv
// ---------------------------------------------------------------------------
// udm_uart_tx
// Device-side UART transmitter for the UDM debug link response path.
// Bytes arrive over a valid/ready handshake into a one-entry holding buffer
// and are sent as: start bit, 8 data bits LSB first, optional parity bit,
// one or two stop bits. Consecutive bytes are sent with no idle gap.
// Line configuration is latched at the start of every frame.
//   clk_i        : system clock
//   arst_i       : asynchronous active-high reset
//   bit_period_i : clocks per bit (0 and 1 both mean 1)
//   parity_en_i  : insert a parity bit
//   parity_odd_i : 1 = odd parity, 0 = even parity
//   stop2_i      : 1 = two stop bits, 0 = one stop bit
//   tx_valid_i   : byte offered
//   tx_data_i    : byte to send
//   tx_ready_o   : holding buffer free (registered)
//   tx_o         : serial line, idles high (registered)
//   busy_o       : a frame is on the line
// ---------------------------------------------------------------------------
module udm_uart_tx
    import udm_uart_pkg::*;
#(
    parameter int BIT_PERIOD_W = 32,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic [BIT_PERIOD_W-1:0] bit_period_i,
    input  logic                    parity_en_i,
    input  logic                    parity_odd_i,
    input  logic                    stop2_i,
    input  logic                    tx_valid_i,
    input  logic [DATA_W-1:0]       tx_data_i,
    output logic                    tx_ready_o,
    output logic                    tx_o,
    output logic                    busy_o
);

    uart_state_e             state_q,     state_d;
    logic [DATA_W-1:0]       shift_q,     shift_d;
    logic [2:0]              bit_idx_q,   bit_idx_d;
    logic                    stop_idx_q,  stop_idx_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0]       buf_data_q,  buf_data_d;
    logic [BIT_PERIOD_W-1:0] period_m1_q, period_m1_d;
    logic                    parity_en_q, parity_en_d;
    logic                    stop2_q,     stop2_d;
    logic                    parity_q,    parity_d;
    logic                    tx_q,        tx_d;

    logic                    xfer;
    logic                    bit_end;
    logic                    frame_done;
    logic                    start_slot;
    logic                    start_now;
    logic [DATA_W-1:0]       start_byte;
    logic [BIT_PERIOD_W-1:0] eff_period;
    logic                    cnt_load;
    logic [BIT_PERIOD_W-1:0] cnt_load_val;

    assign tx_ready_o = !buf_valid_q;
    assign xfer       = tx_valid_i && tx_ready_o;

    // A period of 0 behaves like 1 so the counter never needs to wrap.
    assign eff_period = (bit_period_i > BIT_PERIOD_W'(1)) ? bit_period_i
                                                          : BIT_PERIOD_W'(1);

    // Last cycle of the final stop bit: the line is free from the next cycle.
    assign frame_done = (state_q == STOP) && bit_end && (!stop2_q || stop_idx_q);
    assign start_slot = (state_q == IDLE) || frame_done;

    udm_uart_bitcnt #(
        .CNT_W (BIT_PERIOD_W)
    ) u_bitcnt (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .bit_end_o  (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        period_m1_d  = period_m1_q;
        parity_en_d  = parity_en_q;
        stop2_d      = stop2_q;
        parity_d     = parity_q;
        cnt_load     = 1'b0;
        cnt_load_val = period_m1_q;
        start_now    = 1'b0;
        start_byte   = buf_data_q;

        if (start_slot) begin
            // The buffered byte has priority; otherwise a byte offered right
            // now bypasses the buffer so the frame starts with no gap.
            if (buf_valid_q) begin
                start_now   = 1'b1;
                start_byte  = buf_data_q;
                buf_valid_d = 1'b0;
            end else if (xfer) begin
                start_now  = 1'b1;
                start_byte = tx_data_i;
            end else begin
                state_d = IDLE;
            end
        end else begin
            if (xfer) begin
                buf_valid_d = 1'b1;
                buf_data_d  = tx_data_i;
            end
            if (bit_end && (state_q != IDLE)) begin
                cnt_load = 1'b1;
                unique case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                    DATA: begin
                        if (bit_idx_q == 3'(DATA_W - 1)) begin
                            state_d    = parity_en_q ? PARITY : STOP;
                            stop_idx_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            shift_d   = shift_q >> 1;
                        end
                    end
                    PARITY: begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                    end
                    STOP: begin
                        // Only reached on the first of two stop bits.
                        stop_idx_d = 1'b1;
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        if (start_now) begin
            state_d      = START;
            shift_d      = start_byte;
            bit_idx_d    = '0;
            stop_idx_d   = 1'b0;
            period_m1_d  = eff_period - 1'b1;
            parity_en_d  = parity_en_i;
            stop2_d      = stop2_i;
            parity_d     = parity_bit(start_byte, parity_odd_i);
            cnt_load     = 1'b1;
            cnt_load_val = eff_period - 1'b1;
        end

        // The line level is registered, so it is derived from the next state.
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            period_m1_q <= '0;
            parity_en_q <= 1'b0;
            stop2_q     <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            period_m1_q <= period_m1_d;
            parity_en_q <= parity_en_d;
            stop2_q     <= stop2_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_udm_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_udm_uart_tx
// Self-checking bench for udm_uart_tx. A frame-level model turns each byte
// into its expected line waveform (one entry per clock) and a compare process
// checks tx_o, busy_o and tx_ready_o against it on every falling edge.
// Directed tests add hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_udm_uart_tx;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic [31:0] bit_period_i = 32'd4;
    logic        parity_en_i  = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        stop2_i      = 1'b0;
    logic        tx_valid_i   = 1'b0;
    logic [7:0]  tx_data_i    = 8'h00;
    logic        tx_ready_o;
    logic        tx_o;
    logic        busy_o;

    udm_uart_tx #(
        .BIT_PERIOD_W (32),
        .DATA_W       (8)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .bit_period_i (bit_period_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .tx_valid_i   (tx_valid_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- frame-level model ----------------
    bit         line_q[$];     // expected line level, one entry per future cycle
    logic [7:0] pend;
    bit         have_pend = 1'b0;
    bit         m_ready   = 1'b1;
    bit         acc;
    bit         exp_tx    = 1'b1;
    bit         exp_busy  = 1'b0;
    bit         exp_ready = 1'b1;

    function automatic void expand(input logic [7:0] d);
        bit fb[$];
        int p;
        p = (bit_period_i > 32'd1) ? int'(bit_period_i) : 1;
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(d[i]);
        if (parity_en_i) fb.push_back((^d) ^ parity_odd_i);
        fb.push_back(1'b1);
        if (stop2_i) fb.push_back(1'b1);
        foreach (fb[k]) begin
            for (int r = 0; r < p; r++) line_q.push_back(fb[k]);
        end
    endfunction

    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            line_q.delete();
            have_pend = 1'b0;
            m_ready   = 1'b1;
            exp_tx    = 1'b1;
            exp_busy  = 1'b0;
            exp_ready = 1'b1;
        end else begin
            acc = tx_valid_i && m_ready;
            if (line_q.size() == 0) begin
                if (have_pend) begin
                    expand(pend);
                    have_pend = 1'b0;
                end else if (acc) begin
                    expand(tx_data_i);
                end
            end else if (acc) begin
                pend      = tx_data_i;
                have_pend = 1'b1;
            end
            if (line_q.size() > 0) begin
                exp_busy = 1'b1;
                exp_tx   = line_q.pop_front();
            end else begin
                exp_busy = 1'b0;
                exp_tx   = 1'b1;
            end
            m_ready   = !have_pend;
            exp_ready = m_ready;
        end
    end

    always @(negedge clk_i) begin
        check("tx_o", {31'd0, tx_o}, {31'd0, exp_tx});
        check("busy_o", {31'd0, busy_o}, {31'd0, exp_busy});
        check("tx_ready_o", {31'd0, tx_ready_o}, {31'd0, exp_ready});
    end

    // ---------------- line recorder for literal checks ----------------
    bit rec[$];
    int busy_rises = 0;
    bit busy_prev  = 1'b0;

    always @(negedge clk_i) begin
        if (busy_o === 1'b1) begin
            rec.push_back(tx_o);
            if (!busy_prev) busy_rises++;
        end
        busy_prev = (busy_o === 1'b1);
    end

    function automatic bit rec_at(input int idx);
        if (idx < 0 || idx >= rec.size()) return 1'b0;
        return rec[idx];
    endfunction

    // Host-receiver view: sample the middle of each data bit of a frame.
    function automatic logic [7:0] decode(input int off, input int p);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = rec_at(off + (1 + i) * p + p / 2);
        return d;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int guard;
        guard      = 0;
        tx_valid_i = 1'b1;
        tx_data_i  = d;
        while (!tx_ready_o && guard < 20000) begin
            tick(1);
            guard++;
        end
        if (!tx_ready_o) timeout_fail("send_byte");
        tick(1);
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_o || !tx_ready_o) && n < budget) begin
            tick(1);
            n++;
        end
        if (busy_o || !tx_ready_o) timeout_fail("wait_idle");
    endtask

    initial begin
        arst_i = 1'b1;
        #23;
        check("rst_tx", {31'd0, tx_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, tx_ready_o}, 32'd1);
        arst_i = 1'b0;
        tick(2);

        // P=4, no parity, one stop bit, 0x55
        rec.delete();
        send_byte(8'h55);
        wait_idle(200);
        check("t1_len", rec.size(), 32'd40);
        begin
            logic [9:0] got;
            for (int i = 0; i < 10; i++) got[i] = rec_at(i * 4 + 2);
            check("t1_bits", {22'd0, got}, 32'h2AA);
        end
        check("t1_idle_tx", {31'd0, tx_o}, 32'd1);

        // Even parity on 0x07 (three ones -> parity 1), then odd parity
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b0;
        rec.delete();
        send_byte(8'h07);
        wait_idle(200);
        check("t2_even_len", rec.size(), 32'd44);
        check("t2_even_par", {31'd0, rec_at(9 * 4 + 2)}, 32'd1);
        check("t2_even_data", {24'd0, decode(0, 4)}, 32'h07);
        parity_odd_i = 1'b1;
        rec.delete();
        send_byte(8'h07);
        wait_idle(200);
        check("t2_odd_len", rec.size(), 32'd44);
        check("t2_odd_par", {31'd0, rec_at(9 * 4 + 2)}, 32'd0);

        // Two stop bits, 0xA5 then 0x3C back to back
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        stop2_i      = 1'b1;
        rec.delete();
        busy_rises = 0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        check("t3_ready_drop", {31'd0, tx_ready_o}, 32'd0);
        wait_idle(300);
        check("t3_len", rec.size(), 32'd88);
        check("t3_rises", busy_rises, 32'd1);
        check("t3_last_stop", {31'd0, rec_at(43)}, 32'd1);
        check("t3_second_start", {31'd0, rec_at(44)}, 32'd0);
        check("t3_byte1", {24'd0, decode(0, 4)}, 32'hA5);
        check("t3_byte2", {24'd0, decode(44, 4)}, 32'h3C);

        // 115200 baud at 100 MHz, 0x80
        stop2_i      = 1'b0;
        bit_period_i = 32'd868;
        rec.delete();
        send_byte(8'h80);
        wait_idle(20000);
        check("t4_len", rec.size(), 32'd8680);
        check("t4_start", {31'd0, rec_at(434)}, 32'd0);
        check("t4_data", {24'd0, decode(0, 868)}, 32'h80);
        check("t4_stop", {31'd0, rec_at(9 * 868 + 434)}, 32'd1);

        // Period 0 behaves as 1
        bit_period_i = 32'd0;
        rec.delete();
        send_byte(8'hC3);
        wait_idle(100);
        check("t5_len", rec.size(), 32'd10);
        check("t5_data", {24'd0, decode(0, 1)}, 32'hC3);

        // Reset during data bit 3 of 0x00 with 0x11 buffered
        bit_period_i = 32'd4;
        send_byte(8'h00);
        send_byte(8'h11);
        tick(16);
        #2;
        arst_i = 1'b1;
        #1;
        check("t6_rst_tx", {31'd0, tx_o}, 32'd1);
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_ready", {31'd0, tx_ready_o}, 32'd1);
        #10;
        arst_i = 1'b0;
        rec.delete();
        tick(100);
        check("t6_no_frame", rec.size(), 32'd0);
        check("t6_idle_tx", {31'd0, tx_o}, 32'd1);

        // Period change mid-frame affects only the next frame
        rec.delete();
        send_byte(8'h55);
        tick(10);
        bit_period_i = 32'd8;
        wait_idle(200);
        check("t7_len_p4", rec.size(), 32'd40);
        rec.delete();
        send_byte(8'h55);
        wait_idle(200);
        check("t7_len_p8", rec.size(), 32'd80);
        check("t7_data", {24'd0, decode(0, 8)}, 32'h55);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
